// File: rtl/wb_seq_multiplier_if.sv
// wb_seq_multiplier_if: Wishbone slave signal bundle for the sequential multiplier
interface wb_seq_multiplier_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_seq_multiplier.sv
// wb_seq_multiplier: Wishbone-mapped shift-add multiplier with signed mode, DONE/IRQ and early termination
module wb_seq_multiplier #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_TERM = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_seq_multiplier_if.slave   wb,
    output logic                 irq,
    output logic                 busy_o
);
    localparam int P = 2 * WIDTH;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, mplier_q, mplier_d;
    logic [P-1:0]      mcand_q, mcand_d, acc_q, acc_d, result_q, result_d;
    logic              signed_q, signed_d, ie_q, ie_d, done_q, done_d;
    logic              neg_q, neg_d, op_signed_q, op_signed_d, res_signed_q, res_signed_d;
    logic              ack_q, ack_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       dat_q, dat_d;
    logic              req, wr, rd, start, last, unused_ok;
    logic [1:0]        adr;
    logic [WIDTH-1:0]  abs_a, abs_b, shifted;
    logic [P-1:0]      addend, prod;
    logic [31:0]       result_ext;

    assign req        = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
    assign wr         = req & wb.wbs_we_i;
    assign rd         = req & ~wb.wbs_we_i;
    assign adr        = wb.wbs_adr_i[3:2];
    assign start      = wr && adr == 2'd1 && wb.wbs_dat_i[0] && state_q == IDLE;
    assign abs_a      = (wb.wbs_dat_i[1] && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b      = (wb.wbs_dat_i[1] && b_q[WIDTH-1]) ? -b_q : b_q;
    assign addend     = mplier_q[0] ? mcand_q : '0;
    assign shifted    = mplier_q >> 1;
    assign last       = cnt_q == 5'(WIDTH - 1) || (EARLY_TERM && shifted == '0);
    assign prod       = neg_q ? -acc_q : acc_q;
    assign result_ext = res_signed_q ? 32'(signed'(result_q)) : 32'(result_q);
    assign busy_o     = state_q != IDLE;
    assign irq        = done_q & ie_q;
    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
    assign unused_ok  = ^{wb.wbs_sel_i, wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0]};

    // Next-state for bus response, registers and the shift-add sequencer
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        mplier_d     = mplier_q;
        mcand_d      = mcand_q;
        acc_d        = acc_q;
        result_d     = result_q;
        signed_d     = signed_q;
        ie_d         = ie_q;
        done_d       = done_q;
        neg_d        = neg_q;
        op_signed_d  = op_signed_q;
        res_signed_d = res_signed_q;
        cnt_d        = cnt_q;
        ack_d        = req;
        dat_d        = ~rd ? '0 :
                       adr == 2'd0 ? 32'({a_q, b_q}) :
                       adr == 2'd1 ? {22'd0, done_q, busy_o, 5'd0, ie_q, signed_q, 1'b0} :
                       adr == 2'd2 ? result_ext : '0;
        if (wr && adr == 2'd0) begin
            a_d = wb.wbs_dat_i[P-1:WIDTH];
            b_d = wb.wbs_dat_i[WIDTH-1:0];
        end
        if (wr && adr == 2'd1) begin
            signed_d = wb.wbs_dat_i[1];
            ie_d     = wb.wbs_dat_i[2];
        end
        if (rd && adr == 2'd2)
            done_d = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                mcand_d     = P'(abs_a);
                mplier_d    = abs_b;
                acc_d       = '0;
                cnt_d       = '0;
                neg_d       = wb.wbs_dat_i[1] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                op_signed_d = wb.wbs_dat_i[1];
                done_d      = 1'b0;
                state_d     = RUN;
            end
            RUN: begin
                acc_d    = acc_q + addend;
                mcand_d  = mcand_q << 1;
                mplier_d = shifted;
                cnt_d    = cnt_q + 5'd1;
                state_d  = last ? FIX : RUN;
            end
            FIX: begin
                result_d     = prod;
                res_signed_d = op_signed_q;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register all state; reset discards any in-flight operation
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            mplier_q     <= '0;
            mcand_q      <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            signed_q     <= 1'b0;
            ie_q         <= 1'b0;
            done_q       <= 1'b0;
            neg_q        <= 1'b0;
            op_signed_q  <= 1'b0;
            res_signed_q <= 1'b0;
            cnt_q        <= '0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            mplier_q     <= mplier_d;
            mcand_q      <= mcand_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            signed_q     <= signed_d;
            ie_q         <= ie_d;
            done_q       <= done_d;
            neg_q        <= neg_d;
            op_signed_q  <= op_signed_d;
            res_signed_q <= res_signed_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
        end
    end
endmodule

// File: tb/tb_wb_seq_multiplier.sv
// tb_wb_seq_multiplier: directed tests over three multiplier configurations sharing one bus driver
module tb_wb_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    int          sel = 0;
    int          tests = 0;
    int          fails = 0;
    logic        irq0, irq1, irq2, busy0, busy1, busy2;
    logic        ack_m, busy_m, irq_m;
    logic [31:0] dat_m;

    wb_seq_multiplier_if if0 ();
    wb_seq_multiplier_if if1 ();
    wb_seq_multiplier_if if2 ();

    wb_seq_multiplier #(.WIDTH(8),  .EARLY_TERM(0)) u0 (.wb_clk_i(clk), .wb_rst_i(rst), .wb(if0.slave), .irq(irq0), .busy_o(busy0));
    wb_seq_multiplier #(.WIDTH(8),  .EARLY_TERM(1)) u1 (.wb_clk_i(clk), .wb_rst_i(rst), .wb(if1.slave), .irq(irq1), .busy_o(busy1));
    wb_seq_multiplier #(.WIDTH(16), .EARLY_TERM(1)) u2 (.wb_clk_i(clk), .wb_rst_i(rst), .wb(if2.slave), .irq(irq2), .busy_o(busy2));

    assign if0.wbs_stb_i = stb && sel == 0;
    assign if1.wbs_stb_i = stb && sel == 1;
    assign if2.wbs_stb_i = stb && sel == 2;
    assign {if0.wbs_cyc_i, if1.wbs_cyc_i, if2.wbs_cyc_i} = {3{cyc}};
    assign {if0.wbs_we_i, if1.wbs_we_i, if2.wbs_we_i}    = {3{we}};
    assign {if0.wbs_sel_i, if1.wbs_sel_i, if2.wbs_sel_i} = {3{4'hF}};
    assign {if0.wbs_adr_i, if1.wbs_adr_i, if2.wbs_adr_i} = {3{adr}};
    assign {if0.wbs_dat_i, if1.wbs_dat_i, if2.wbs_dat_i} = {3{wdat}};
    assign ack_m  = sel == 0 ? if0.wbs_ack_o : sel == 1 ? if1.wbs_ack_o : if2.wbs_ack_o;
    assign dat_m  = sel == 0 ? if0.wbs_dat_o : sel == 1 ? if1.wbs_dat_o : if2.wbs_dat_o;
    assign busy_m = sel == 0 ? busy0 : sel == 1 ? busy1 : busy2;
    assign irq_m  = sel == 0 ? irq0 : sel == 1 ? irq1 : irq2;

    always #5 clk = ~clk;

    // One bus access; returns at the falling edge of the ack cycle
    task automatic bus(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        int n;
        @(negedge clk);
        sel = d; stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack_m && n < 4);
        rd = dat_m;
        if (!ack_m) begin
            tests++; fails++;
            $display("FAIL bus_timeout dev=%0d adr=%h: no ack within 4 cycles", d, a);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] x;
        bus(d, 1'b1, a, wd, x);
    endtask

    task automatic rd(input int d, input logic [31:0] a, output logic [31:0] v);
        bus(d, 1'b0, a, 32'h0, v);
    endtask

    // Counts busy cycles starting at the current (ack) cycle
    task automatic wait_idle(output int n);
        n = 0;
        while (busy_m && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({if0.wbs_ack_o, if1.wbs_ack_o, if2.wbs_ack_o, irq0, irq1, irq2, busy0, busy1, busy2} !== 9'b0) begin
            fails++; $display("FAIL reset_outputs got ack/irq/busy nonzero, required all 0");
        end
        tests++;
        if ((if0.wbs_dat_o | if1.wbs_dat_o | if2.wbs_dat_o) !== 32'h0) begin
            fails++; $display("FAIL reset_dat_o got %h, required 0", if0.wbs_dat_o | if1.wbs_dat_o | if2.wbs_dat_o);
        end
        for (int r = 0; r < 3; r++) begin
            rd(0, 32'(r * 4), v);
            tests++;
            if (v !== 32'h0) begin
                fails++; $display("FAIL reset_reg%0d got %h, required 0", r, v);
            end
        end
    endtask

    task automatic test_regs;
        logic [31:0] v;
        wr(0, 32'h0, 32'hFFFFFFFF);
        rd(0, 32'h0, v);
        tests++;
        if (v !== 32'h0000FFFF) begin fails++; $display("FAIL ops_w8 got %h, required 0000ffff", v); end
        wr(2, 32'h0, 32'hFFFFFFFF);
        rd(2, 32'h0, v);
        tests++;
        if (v !== 32'hFFFFFFFF) begin fails++; $display("FAIL ops_w16 got %h, required ffffffff", v); end
        wr(0, 32'h4, 32'h6);
        rd(0, 32'h4, v);
        tests++;
        if (v !== 32'h6) begin fails++; $display("FAIL ctrl_rw got %h, required 00000006", v); end
        wr(0, 32'h4, 32'h0);
        wr(0, 32'hC, 32'hDEADBEEF);
        rd(0, 32'hC, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL reg_c got %h, required 0", v); end
        wr(0, 32'h8, 32'h12345678);
        rd(0, 32'h8, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL result_ro got %h, required 0", v); end
    endtask

    task automatic test_ack;
        int acks, dbl;
        logic prev;
        @(negedge clk);
        sel = 0; stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 32'hC;
        acks = 0; dbl = 0; prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack_m) acks++;
            if (ack_m && prev) dbl++;
            prev = ack_m;
        end
        stb = 1'b0; cyc = 1'b0;
        tests++;
        if (acks != 2 || dbl != 0) begin
            fails++; $display("FAIL ack_pulse got acks=%0d back_to_back=%0d, required acks=2 back_to_back=0", acks, dbl);
        end
    endtask

    task automatic test_unsigned_fixed;
        logic [31:0] v;
        int n;
        wr(0, 32'h0, 32'h0000FFFF);
        wr(0, 32'h4, 32'h1);
        wait_idle(n);
        tests++;
        if (n != 9) begin fails++; $display("FAIL latency_et0 got %0d, required 9", n); end
        tests++;
        if (busy_m !== 1'b0) begin fails++; $display("FAIL busy_after got %b, required 0", busy_m); end
        rd(0, 32'h4, v);
        tests++;
        if (v !== 32'h200) begin fails++; $display("FAIL done_et0 got %h, required 00000200", v); end
        rd(0, 32'h8, v);
        tests++;
        if (v !== 32'h0000FE01) begin fails++; $display("FAIL result_ffxff got %h, required 0000fe01", v); end
        rd(0, 32'h4, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL done_clear got %h, required 0", v); end
    endtask

    task automatic test_signed;
        logic [31:0] ops [3] = '{32'h8080, 32'hFF02, 32'h05FD};
        logic [31:0] exp [3] = '{32'h00004000, 32'hFFFFFFFE, 32'hFFFFFFF1};
        logic [31:0] v;
        int n;
        for (int i = 0; i < 3; i++) begin
            wr(0, 32'h0, ops[i]);
            wr(0, 32'h4, 32'h3);
            wait_idle(n);
            rd(0, 32'h8, v);
            tests++;
            if (v !== exp[i]) begin fails++; $display("FAIL signed_%0d got %h, required %h", i, v, exp[i]); end
        end
        wr(0, 32'h4, 32'h0);
    endtask

    task automatic test_early_term;
        logic [31:0] v;
        int n;
        wr(1, 32'h0, 32'h7B03);
        wr(1, 32'h4, 32'h1);
        wait_idle(n);
        tests++;
        if (n != 3) begin fails++; $display("FAIL latency_et1 got %0d, required 3", n); end
        rd(1, 32'h8, v);
        tests++;
        if (v !== 32'h171) begin fails++; $display("FAIL result_et1 got %h, required 00000171", v); end
        wr(1, 32'h0, 32'h7B00);
        wr(1, 32'h4, 32'h1);
        wait_idle(n);
        tests++;
        if (n != 2) begin fails++; $display("FAIL latency_b0 got %0d, required 2", n); end
        rd(1, 32'h8, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL result_b0 got %h, required 0", v); end
    endtask

    task automatic test_busy_writes;
        logic [31:0] v;
        int n;
        wr(0, 32'h0, 32'h0A0B);
        wr(0, 32'h4, 32'h1);
        wr(0, 32'h0, 32'h0202);
        wr(0, 32'h4, 32'h1);
        tests++;
        if (busy_m !== 1'b1) begin fails++; $display("FAIL busy_during_run got %b, required 1", busy_m); end
        wait_idle(n);
        rd(0, 32'h8, v);
        tests++;
        if (v !== 32'h6E) begin fails++; $display("FAIL in_flight got %h, required 0000006e", v); end
        wr(0, 32'h4, 32'h1);
        wait_idle(n);
        rd(0, 32'h8, v);
        tests++;
        if (v !== 32'h4) begin fails++; $display("FAIL new_ops got %h, required 00000004", v); end
    endtask

    task automatic test_reset_mid_run;
        logic [31:0] v;
        int n;
        wr(0, 32'h0, 32'hFFFF);
        wr(0, 32'h4, 32'h7);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (busy_m !== 1'b0 || irq_m !== 1'b0) begin
            fails++; $display("FAIL rst_mid busy=%b irq=%b, required 0 0", busy_m, irq_m);
        end
        rd(0, 32'h4, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL rst_mid_ctrl got %h, required 0", v); end
        rd(0, 32'h8, v);
        tests++;
        if (v !== 32'h0) begin fails++; $display("FAIL rst_mid_result got %h, required 0", v); end
        wr(0, 32'h0, 32'h1234);
        wr(0, 32'h4, 32'h1);
        wait_idle(n);
        rd(0, 32'h8, v);
        tests++;
        if (v !== 32'h3A8) begin fails++; $display("FAIL after_rst got %h, required 000003a8", v); end
    endtask

    task automatic test_w16_irq;
        logic [31:0] v;
        int n;
        wr(2, 32'h0, 32'hFFFFFFFF);
        wr(2, 32'h4, 32'h5);
        wait_idle(n);
        tests++;
        if (n != 17) begin fails++; $display("FAIL latency_w16 got %0d, required 17", n); end
        repeat (2) @(negedge clk);
        tests++;
        if (irq_m !== 1'b1) begin fails++; $display("FAIL irq_high got %b, required 1", irq_m); end
        rd(2, 32'h8, v);
        tests++;
        if (v !== 32'hFFFE0001) begin fails++; $display("FAIL result_w16 got %h, required fffe0001", v); end
        @(negedge clk);
        tests++;
        if (irq_m !== 1'b0) begin fails++; $display("FAIL irq_low got %b, required 0", irq_m); end
    endtask

    initial begin
        test_reset;
        test_regs;
        test_ack;
        test_unsigned_fixed;
        test_signed;
        test_early_term;
        test_busy_writes;
        test_reset_mid_run;
        test_w16_irq;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
